instrumentation_scan_ctrl: RTL and testbench

- Sequential controller that scans the three instrumentation channels (0 = temperature, 1 = pressure, 2 = saturation margin) once per `start` pulse.
- For each channel it requests a 32-bit sensor sample over a req/valid handshake and compares the sample against that channel's setpoint.
- It applies the per-channel mode, then publishes a registered 3-bit channel-trip vector to the voting logic.
- It owns the setpoint register bank (written by the configuration interface) and provides fail-safe timeout handling for sensors that do not respond.

---
 rtl/instrumentation_scan_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_instrumentation_scan_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instrumentation_scan_ctrl.sv
// Instrumentation scan controller: samples each channel over a req/valid
// handshake, compares against a snapshotted setpoint, applies the channel
// mode and publishes a registered trip vector with fail-safe timeouts.
module instrumentation_scan_ctrl #(
    parameter int unsigned NChannels = 3,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [2*NChannels-1:0] mode,
    input  logic                   cfg_we,
    input  logic [1:0]             cfg_ch,
    input  logic [31:0]            cfg_data,
    output logic                   sensor_req,
    output logic [1:0]             sensor_ch,
    input  logic                   sensor_valid,
    input  logic [31:0]            sensor_data,
    output logic                   busy,
    output logic                   done,
    output logic [NChannels-1:0]   trip,
    output logic                   trip_valid,
    output logic [NChannels-1:0]   timeout_err
);

    typedef enum logic [1:0] {StIdle, StReq, StEval, StDone} state_e;

    state_e state_q, state_d;

    logic [31:0]            setpoint_q  [NChannels];
    logic [31:0]            sp_snap_q   [NChannels];
    logic [2*NChannels-1:0] mode_snap_q;
    logic [1:0]             idx_q;
    logic [7:0]             cnt_q;
    logic [31:0]            sample_q;
    logic                   timed_out_q;
    logic [NChannels-1:0]   pend_q;
    logic [NChannels-1:0]   trip_q;
    logic                   trip_valid_q;
    logic [NChannels-1:0]   timeout_err_q;

    logic [1:0]             ch_mode;
    logic [31:0]            ch_sp;
    logic                   sens_trip;
    logic                   ch_trip;
    logic                   last_ch;
    logic                   timeout_hit;
    logic [NChannels-1:0]   pend_next;

    // Per-channel evaluation from the snapshot; channel 0 mode sits in the MSBs.
    always_comb begin
        ch_mode = 2'b00;
        ch_sp   = 32'd0;
        for (int i = 0; i < NChannels; i++) begin
            if (idx_q == 2'(i)) begin
                ch_mode = mode_snap_q[2*(NChannels-1-i) +: 2];
                ch_sp   = sp_snap_q[i];
            end
        end
        if (timed_out_q) begin
            sens_trip = 1'b1;
        end else if (idx_q == 2'd2) begin
            // Saturation margin is a signed low-limit.
            sens_trip = $signed(sample_q) < $signed(ch_sp);
        end else begin
            sens_trip = sample_q > ch_sp;
        end
        ch_trip     = (ch_mode == 2'd2) | ((ch_mode == 2'd1) & sens_trip);
        last_ch     = (idx_q == 2'(NChannels - 1));
        timeout_hit = (cnt_q == 8'(TIMEOUT - 1));
        pend_next   = pend_q;
        for (int i = 0; i < NChannels; i++) begin
            if (idx_q == 2'(i)) begin
                pend_next[i] = ch_trip;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake/status outputs.
    always_comb begin
        state_d    = state_q;
        sensor_req = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                sensor_req = 1'b1;
                // A valid in the final wait cycle wins over the timeout.
                if (sensor_valid || timeout_hit) begin
                    state_d = StEval;
                end
            end
            StEval: begin
                state_d = last_ch ? StDone : StReq;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Setpoint bank, snapshot and scan datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NChannels; i++) begin
                setpoint_q[i] <= 32'd0;
                sp_snap_q[i]  <= 32'd0;
            end
            mode_snap_q   <= '0;
            idx_q         <= 2'd0;
            cnt_q         <= 8'd0;
            sample_q      <= 32'd0;
            timed_out_q   <= 1'b0;
            pend_q        <= '0;
            trip_q        <= '0;
            trip_valid_q  <= 1'b0;
            timeout_err_q <= '0;
        end else begin
            for (int i = 0; i < NChannels; i++) begin
                if (cfg_we && cfg_ch == 2'(i)) begin
                    setpoint_q[i] <= cfg_data;
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        // Write-first: a coincident config write joins this scan.
                        for (int i = 0; i < NChannels; i++) begin
                            sp_snap_q[i] <= (cfg_we && cfg_ch == 2'(i)) ? cfg_data
                                                                         : setpoint_q[i];
                        end
                        mode_snap_q   <= mode;
                        idx_q         <= 2'd0;
                        cnt_q         <= 8'd0;
                        pend_q        <= '0;
                        timeout_err_q <= '0;
                    end
                end
                StReq: begin
                    if (sensor_valid) begin
                        sample_q    <= sensor_data;
                        timed_out_q <= 1'b0;
                        cnt_q       <= 8'd0;
                    end else if (timeout_hit) begin
                        timed_out_q <= 1'b1;
                        cnt_q       <= 8'd0;
                        for (int i = 0; i < NChannels; i++) begin
                            if (idx_q == 2'(i)) begin
                                timeout_err_q[i] <= 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StEval: begin
                    pend_q <= pend_next;
                    if (last_ch) begin
                        // Publish on entry to DONE so trip and done appear together.
                        trip_q       <= pend_next;
                        trip_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 2'd1;
                    end
                end
                StDone: begin
                    idx_q <= 2'd0;
                end
                default: ;
            endcase
        end
    end

    assign sensor_ch   = idx_q;
    assign trip        = trip_q;
    assign trip_valid  = trip_valid_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_instrumentation_scan_ctrl.sv
// Scoreboard bench for instrumentation_scan_ctrl: scans push expected results,
// a monitor pops and compares on every done pulse.
module tb_instrumentation_scan_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  mode;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_data;
    logic        sensor_req;
    logic [1:0]  sensor_ch;
    logic        sensor_valid;
    logic [31:0] sensor_data;
    logic        busy;
    logic        done;
    logic [2:0]  trip;
    logic        trip_valid;
    logic [2:0]  timeout_err;

    always #5 clk = ~clk;

    instrumentation_scan_ctrl #(
        .NChannels(3),
        .TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_data    (cfg_data),
        .sensor_req  (sensor_req),
        .sensor_ch   (sensor_ch),
        .sensor_valid(sensor_valid),
        .sensor_data (sensor_data),
        .busy        (busy),
        .done        (done),
        .trip        (trip),
        .trip_valid  (trip_valid),
        .timeout_err (timeout_err)
    );

    typedef struct packed {
        logic [2:0] trip;
        logic [2:0] to;
    } exp_t;

    exp_t q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;
    int   nscans   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Sensor model: per-channel sample and wait cycles (wait >= TO never answers).
    logic [31:0] samp     [3];
    int          wait_cyc [3];
    int          last_len [3];
    int          wcnt = 0;
    logic [1:0]  last_ch = 2'd0;

    always @(negedge clk) begin
        if (!sensor_req) begin
            if (wcnt > 0) last_len[last_ch] = wcnt;
            wcnt         = 0;
            sensor_valid = 1'b0;
        end else begin
            last_ch      = sensor_ch;
            sensor_valid = (wcnt == wait_cyc[sensor_ch]);
            sensor_data  = samp[sensor_ch];
            wcnt++;
        end
    end

    // Monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done) begin
            done_cnt++;
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("trip", 32'(trip), 32'(e.trip));
                check("timeout_err", 32'(timeout_err), 32'(e.to));
                check("trip_valid", 32'(trip_valid), 32'd1);
            end
        end
    end

    // Side stimulus applied at a given cycle of a scan (0 = with start).
    int          side_at    = -1;
    logic        side_start = 1'b0;
    logic        side_we    = 1'b0;
    logic [1:0]  side_ch    = 2'd0;
    logic [31:0] side_data  = 32'd0;

    task automatic apply_side();
        start    = side_start;
        cfg_we   = side_we;
        cfg_ch   = side_ch;
        cfg_data = side_data;
    endtask

    task automatic set_samples(input logic [31:0] s0, input logic [31:0] s1,
                               input logic [31:0] s2);
        samp[0] = s0;
        samp[1] = s1;
        samp[2] = s2;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [31:0] d);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_data = d;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic run_scan(input logic [5:0] m, input logic [2:0] et, input logic [2:0] eto,
                            input int elat);
        exp_t e;
        int   lat;
        bit   seen;
        e.trip = et;
        e.to   = eto;
        q.push_back(e);
        nscans++;
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        if (side_at == 0) apply_side();
        seen = 0;
        lat  = 0;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            start  = 1'b0;
            cfg_we = 1'b0;
            if (lat == side_at) apply_side();
            #1;
            if (done) seen = 1;
        end
        if (!seen) check("scan_timeout", 32'd0, 32'd1);
        else check("latency", 32'(lat), 32'(elat));
        side_at = -1;
        start   = 1'b0;
        cfg_we  = 1'b0;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        rst_n    = 1'b0;
        start    = 1'b0;
        mode     = 6'b01_01_01;
        cfg_we   = 1'b0;
        cfg_ch   = 2'd0;
        cfg_data = 32'd0;
        sensor_valid = 1'b0;
        sensor_data  = 32'd0;
        for (int i = 0; i < 3; i++) begin
            wait_cyc[i] = 0;
            last_len[i] = 0;
            samp[i]     = 32'd0;
        end
        repeat (3) @(negedge clk);

        check("rst_sensor_req", 32'(sensor_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_trip", 32'(trip), 32'd0);
        check("rst_trip_valid", 32'(trip_valid), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_sensor_ch", 32'(sensor_ch), 32'd0);

        rst_n = 1'b1;
        cfg_write(2'd0, 32'd100);
        cfg_write(2'd1, 32'd200);
        cfg_write(2'd2, 32'hFFFF_FFFB);  // -5

        // 101 > 100 trips, 200 == 200 does not, -6 < -5 trips.
        set_samples(32'd101, 32'd200, 32'hFFFF_FFFA);
        run_scan(6'b01_01_01, 3'b101, 3'b000, 7);

        // Modes {bypass, manual trip, 3}: only channel 1 trips either way.
        set_samples(32'd50, 32'd100, 32'd0);
        run_scan(6'b00_10_11, 3'b010, 3'b000, 7);
        set_samples(32'd150, 32'd300, 32'hFFFF_FF9C);
        run_scan(6'b00_10_11, 3'b010, 3'b000, 7);

        // Channel 1 silent: fail-safe trip, 4 request cycles, 3 extra cycles.
        set_samples(32'd50, 32'd100, 32'd0);
        wait_cyc[1] = 99;
        run_scan(6'b01_01_01, 3'b010, 3'b010, 10);
        check("ch1_req_len_timeout", 32'(last_len[1]), 32'd4);

        // Valid in the 4th wait cycle is accepted; sample 300 > 200 trips.
        wait_cyc[1] = 3;
        set_samples(32'd50, 32'd300, 32'd0);
        run_scan(6'b01_01_01, 3'b010, 3'b000, 10);
        check("ch1_req_len_late_valid", 32'(last_len[1]), 32'd4);
        wait_cyc[1] = 0;

        // Mid-scan write of setpoint 0 to 50 affects only the next scan.
        set_samples(32'd60, 32'd100, 32'd0);
        side_at    = 2;
        side_start = 1'b0;
        side_we    = 1'b1;
        side_ch    = 2'd0;
        side_data  = 32'd50;
        run_scan(6'b01_01_01, 3'b000, 3'b000, 7);
        run_scan(6'b01_01_01, 3'b001, 3'b000, 7);

        // Write coincident with start (setpoint 0 to 70) is used by that scan.
        side_at    = 0;
        side_start = 1'b1;
        side_we    = 1'b1;
        side_ch    = 2'd0;
        side_data  = 32'd70;
        run_scan(6'b01_01_01, 3'b000, 3'b000, 7);

        // start while busy and a cfg_ch=3 write are both ignored.
        side_at    = 3;
        side_start = 1'b1;
        side_we    = 1'b1;
        side_ch    = 2'd3;
        side_data  = 32'd0;
        run_scan(6'b01_01_01, 3'b000, 3'b000, 7);
        // Setpoints still {70, 200, -5}: only -6 < -5 trips.
        set_samples(32'd60, 32'd150, 32'hFFFF_FFFA);
        run_scan(6'b01_01_01, 3'b100, 3'b000, 7);
        repeat (3) @(negedge clk);
        check("scan_count", 32'(done_cnt), 32'(nscans));

        // Reset while requesting channel 1.
        wait_cyc[1] = 99;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (sensor_req && sensor_ch == 2'd1) found = 1;
            else @(negedge clk);
        end
        check("reach_req_ch1", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_sensor_req", 32'(sensor_req), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_trip", 32'(trip), 32'd0);
        check("abort_trip_valid", 32'(trip_valid), 32'd0);
        check("abort_timeout_err", 32'(timeout_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc[1] = 0;

        // Setpoints are back to 0: 1 > 0 trips, 0 == 0 does not, 0 < 0 does not.
        set_samples(32'd1, 32'd0, 32'd0);
        run_scan(6'b01_01_01, 3'b001, 3'b000, 7);
        repeat (3) @(negedge clk);
        check("final_scan_count", 32'(done_cnt), 32'(nscans));
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
